// File: rtl/multi_channel_temp_monitor.sv
// Multi-channel temperature monitor: per-channel linear calibration with saturation and
// debounced low/high alarms with hysteresis. Define TMON_STICKY_ALARM_EN for sticky alarms.
module multi_channel_temp_monitor #(
  parameter int NCH     = 4,
  parameter int BW      = 5,
  parameter int CW      = 4,
  parameter int SW      = 4,
  parameter int TW      = 9,
  parameter int LOW_TH  = 20,
  parameter int HIGH_TH = 200,
  parameter int HYST    = 10,
  parameter int DEB     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [BW-1:0]          cfg_base,
  input  logic [CW-1:0]          cfg_coef,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [$clog2(NCH)-1:0] sample_ch,
  input  logic [SW-1:0]          sample_value,
  output logic                   temp_valid,
  output logic [$clog2(NCH)-1:0] temp_ch,
  output logic [TW-1:0]          temp_out,
  output logic                   ch_err,
  output logic [NCH-1:0]         low_alarm,
  output logic [NCH-1:0]         high_alarm,
  input  logic [NCH-1:0]         alarm_clr
);

  localparam int CHW = $clog2(NCH);
  localparam int FW  = BW + CW + SW + 1;
  localparam int PW  = (FW > TW) ? FW : TW;
  localparam int DW  = $clog2(DEB + 1);
  localparam logic [DW-1:0] DEB_C = DEB[DW-1:0];

  logic                 ready_q;
  logic [BW-1:0]        base_q [NCH];
  logic [BW-1:0]        base_d [NCH];
  logic [CW-1:0]        coef_q [NCH];
  logic [CW-1:0]        coef_d [NCH];

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_err_q, s1_err_d;
  logic [CHW-1:0]       s1_ch_q, s1_ch_d;
  logic [TW-1:0]        s1_temp_q, s1_temp_d;

  logic                 temp_valid_q, temp_valid_d;
  logic [CHW-1:0]       temp_ch_q, temp_ch_d;
  logic [TW-1:0]        temp_out_q, temp_out_d;
  logic                 ch_err_q, ch_err_d;

  logic [DW-1:0]        hi_cnt_q [NCH];
  logic [DW-1:0]        hi_cnt_d [NCH];
  logic [DW-1:0]        lo_cnt_q [NCH];
  logic [DW-1:0]        lo_cnt_d [NCH];
  logic [NCH-1:0]       high_alarm_q, high_alarm_d;
  logic [NCH-1:0]       low_alarm_q, low_alarm_d;

  logic                 accept_s;
  logic                 bad_ch_s;
  logic [CHW-1:0]       idx_s;
  logic [PW-1:0]        full_s;
  logic [TW-1:0]        temp_s;

  logic                 hi_gt_s, hi_le_hyst_s, lo_lt_s, lo_ge_hyst_s;
  logic [NCH-1:0]       hit_s, hi_set_s, hi_clr_s, lo_set_s, lo_clr_s;

  // Sample acceptance and saturating calibration using the config held before this edge.
  always_comb begin
    accept_s = sample_valid & sample_ready;
    bad_ch_s = (int'(sample_ch) >= NCH);
    if (bad_ch_s) begin
      idx_s = {CHW{1'b0}};
    end else begin
      idx_s = sample_ch;
    end
    full_s = PW'(base_q[idx_s]) + PW'(coef_q[idx_s]) * PW'(sample_value);
    if (|(full_s >> TW)) begin
      temp_s = {TW{1'b1}};
    end else begin
      temp_s = full_s[TW-1:0];
    end
  end

  // Configuration register file write.
  always_comb begin
    base_d = base_q;
    coef_d = coef_q;
    if (cfg_we && (int'(cfg_ch) < NCH)) begin
      base_d[cfg_ch] = cfg_base;
      coef_d[cfg_ch] = cfg_coef;
    end else begin
      base_d = base_q;
      coef_d = coef_q;
    end
  end

  // Two-stage result pipeline: calibrated stage, then the visible result stage.
  always_comb begin
    s1_valid_d   = accept_s & ~bad_ch_s;
    s1_err_d     = accept_s & bad_ch_s;
    s1_temp_d    = temp_s;
    if (accept_s) begin
      s1_ch_d = sample_ch;
    end else begin
      s1_ch_d = s1_ch_q;
    end
    temp_valid_d = s1_valid_q;
    ch_err_d     = s1_err_q;
    if (s1_valid_q) begin
      temp_ch_d  = s1_ch_q;
      temp_out_d = s1_temp_q;
    end else begin
      temp_ch_d  = temp_ch_q;
      temp_out_d = temp_out_q;
    end
  end

  // Debounce counters and alarm flags, updated from the visible result one edge later.
  always_comb begin
    hi_gt_s      = (int'(temp_out_q) > HIGH_TH);
    hi_le_hyst_s = (int'(temp_out_q) <= (HIGH_TH - HYST));
    lo_lt_s      = (int'(temp_out_q) < LOW_TH);
    lo_ge_hyst_s = (int'(temp_out_q) >= (LOW_TH + HYST));
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    hit_s        = {NCH{1'b0}};
    hi_set_s     = {NCH{1'b0}};
    hi_clr_s     = {NCH{1'b0}};
    lo_set_s     = {NCH{1'b0}};
    lo_clr_s     = {NCH{1'b0}};
    high_alarm_d = high_alarm_q;
    low_alarm_d  = low_alarm_q;
    for (int i = 0; i < NCH; i++) begin
      hit_s[i] = temp_valid_q && (int'(temp_ch_q) == i);
      if (hit_s[i]) begin
        if (hi_gt_s) begin
          hi_cnt_d[i] = (hi_cnt_q[i] == DEB_C) ? DEB_C : hi_cnt_q[i] + 1'b1;
        end else begin
          hi_cnt_d[i] = {DW{1'b0}};
        end
        if (lo_lt_s) begin
          lo_cnt_d[i] = (lo_cnt_q[i] == DEB_C) ? DEB_C : lo_cnt_q[i] + 1'b1;
        end else begin
          lo_cnt_d[i] = {DW{1'b0}};
        end
      end else begin
        hi_cnt_d[i] = hi_cnt_q[i];
        lo_cnt_d[i] = lo_cnt_q[i];
      end
      hi_set_s[i] = hit_s[i] && hi_gt_s && (hi_cnt_d[i] == DEB_C);
      lo_set_s[i] = hit_s[i] && lo_lt_s && (lo_cnt_d[i] == DEB_C);
`ifdef TMON_STICKY_ALARM_EN
      hi_clr_s[i] = alarm_clr[i];
      lo_clr_s[i] = alarm_clr[i];
`else
      hi_clr_s[i] = hit_s[i] && hi_le_hyst_s;
      lo_clr_s[i] = hit_s[i] && lo_ge_hyst_s;
`endif
      // Set has priority over clear when both land on the same edge.
      high_alarm_d[i] = hi_set_s[i] | (high_alarm_q[i] & ~hi_clr_s[i]);
      low_alarm_d[i]  = lo_set_s[i] | (low_alarm_q[i] & ~lo_clr_s[i]);
    end
  end

`ifndef TMON_STICKY_ALARM_EN
  logic unused_alarm_clr_s;
  assign unused_alarm_clr_s = ^alarm_clr;
`endif

  // State registers with synchronous reset; reset also flushes samples in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_ch_q      <= {CHW{1'b0}};
      s1_temp_q    <= {TW{1'b0}};
      temp_valid_q <= 1'b0;
      temp_ch_q    <= {CHW{1'b0}};
      temp_out_q   <= {TW{1'b0}};
      ch_err_q     <= 1'b0;
      high_alarm_q <= {NCH{1'b0}};
      low_alarm_q  <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        base_q[i]   <= {BW{1'b0}};
        coef_q[i]   <= {CW{1'b0}};
        hi_cnt_q[i] <= {DW{1'b0}};
        lo_cnt_q[i] <= {DW{1'b0}};
      end
    end else begin
      ready_q      <= 1'b1;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s1_ch_q      <= s1_ch_d;
      s1_temp_q    <= s1_temp_d;
      temp_valid_q <= temp_valid_d;
      temp_ch_q    <= temp_ch_d;
      temp_out_q   <= temp_out_d;
      ch_err_q     <= ch_err_d;
      high_alarm_q <= high_alarm_d;
      low_alarm_q  <= low_alarm_d;
      base_q       <= base_d;
      coef_q       <= coef_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
    end
  end

  // Ready drops combinationally with rst so no sample is taken while reset is asserted.
  assign sample_ready = ready_q & ~rst;
  assign temp_valid   = temp_valid_q;
  assign temp_ch      = temp_ch_q;
  assign temp_out     = temp_out_q;
  assign ch_err       = ch_err_q;
  assign high_alarm   = high_alarm_q;
  assign low_alarm    = low_alarm_q;

endmodule

// File: tb/tb_multi_channel_temp_monitor.sv
// Directed bench for multi_channel_temp_monitor: default instance plus an NCH=3/TW=8 instance.
module tb_multi_channel_temp_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [4:0] cfg_base;
  logic [3:0] cfg_coef;
  logic       sample_valid, sample_ready;
  logic [1:0] sample_ch;
  logic [3:0] sample_value;
  logic       temp_valid;
  logic [1:0] temp_ch;
  logic [8:0] temp_out;
  logic       ch_err;
  logic [3:0] low_alarm, high_alarm, alarm_clr;

  logic       cfg_we_b;
  logic [1:0] cfg_ch_b;
  logic [4:0] cfg_base_b;
  logic [3:0] cfg_coef_b;
  logic       sample_valid_b, sample_ready_b;
  logic [1:0] sample_ch_b;
  logic [3:0] sample_value_b;
  logic       temp_valid_b;
  logic [1:0] temp_ch_b;
  logic [7:0] temp_out_b;
  logic       ch_err_b;
  logic [2:0] low_alarm_b, high_alarm_b, alarm_clr_b;

  int errors = 0;
  int checks = 0;

  multi_channel_temp_monitor dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_coef(cfg_coef),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_ch(sample_ch), .sample_value(sample_value),
    .temp_valid(temp_valid), .temp_ch(temp_ch), .temp_out(temp_out), .ch_err(ch_err),
    .low_alarm(low_alarm), .high_alarm(high_alarm), .alarm_clr(alarm_clr)
  );

  multi_channel_temp_monitor #(.NCH(3), .TW(8)) dut_b (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b), .cfg_base(cfg_base_b), .cfg_coef(cfg_coef_b),
    .sample_valid(sample_valid_b), .sample_ready(sample_ready_b),
    .sample_ch(sample_ch_b), .sample_value(sample_value_b),
    .temp_valid(temp_valid_b), .temp_ch(temp_ch_b), .temp_out(temp_out_b), .ch_err(ch_err_b),
    .low_alarm(low_alarm_b), .high_alarm(high_alarm_b), .alarm_clr(alarm_clr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [1:0] ch, input logic [4:0] base, input logic [3:0] coef);
    cfg_we = 1'b1; cfg_ch = ch; cfg_base = base; cfg_coef = coef;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_b(input logic [1:0] ch, input logic [4:0] base, input logic [3:0] coef);
    cfg_we_b = 1'b1; cfg_ch_b = ch; cfg_base_b = base; cfg_coef_b = coef;
    tick();
    cfg_we_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", sample_ready);
    end
    checks++;
    if (temp_valid !== 1'b0 || temp_out !== 9'd0 || temp_ch !== 2'd0 || ch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b out=%0d ch=%0d err=%b want all 0",
               temp_valid, temp_out, temp_ch, ch_err);
    end
    checks++;
    if (high_alarm !== 4'd0 || low_alarm !== 4'd0) begin
      errors++; $display("FAIL reset_alarms: got hi=%b lo=%b want 0", high_alarm, low_alarm);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL ready_after_rst: got %b want 0", sample_ready);
    end
    tick();
    checks++;
    if (sample_ready !== 1'b1 || sample_ready_b !== 1'b1) begin
      errors++; $display("FAIL ready_up: got %b/%b want 1/1", sample_ready, sample_ready_b);
    end
  endtask

  task automatic test_high_alarm();
    cfg_a(2'd0, 5'd10, 4'd15);
    sample_valid = 1'b1; sample_ch = 2'd0; sample_value = 4'd15;
    tick();
    checks++;
    if (temp_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: got valid=%b want 0", temp_valid);
    end
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd235 || temp_ch !== 2'd0) begin
      errors++; $display("FAIL hi_temp1: got v=%b out=%0d ch=%0d want 1/235/0", temp_valid, temp_out, temp_ch);
    end
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd235) begin
      errors++; $display("FAIL hi_temp2: got v=%b out=%0d want 1/235", temp_valid, temp_out);
    end
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd235 || high_alarm !== 4'b0000) begin
      errors++; $display("FAIL hi_early: got v=%b out=%0d hi=%b want 1/235/0000", temp_valid, temp_out, high_alarm);
    end
    tick();
    checks++;
    if (high_alarm !== 4'b0001 || temp_valid !== 1'b0) begin
      errors++; $display("FAIL hi_set: got hi=%b v=%b want 0001/0", high_alarm, temp_valid);
    end
  endtask

  task automatic test_hysteresis();
    cfg_a(2'd0, 5'd15, 4'd15);
    sample_valid = 1'b1; sample_ch = 2'd0; sample_value = 4'd12;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_out !== 9'd195) begin
      errors++; $display("FAIL hyst_temp195: got %0d want 195", temp_out);
    end
    tick();
    checks++;
    if (high_alarm !== 4'b0001) begin
      errors++; $display("FAIL hyst_hold: got hi=%b want 0001", high_alarm);
    end
    cfg_a(2'd0, 5'd10, 4'd15);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_out !== 9'd190) begin
      errors++; $display("FAIL hyst_temp190: got %0d want 190", temp_out);
    end
    tick();
`ifdef TMON_STICKY_ALARM_EN
    checks++;
    if (high_alarm !== 4'b0001) begin
      errors++; $display("FAIL sticky_hold: got hi=%b want 0001", high_alarm);
    end
    alarm_clr = 4'b0001;
    tick();
    alarm_clr = 4'b0000;
    checks++;
    if (high_alarm !== 4'b0000) begin
      errors++; $display("FAIL sticky_clr: got hi=%b want 0000", high_alarm);
    end
`else
    checks++;
    if (high_alarm !== 4'b0000) begin
      errors++; $display("FAIL hyst_clear: got hi=%b want 0000", high_alarm);
    end
`endif
  endtask

  task automatic test_low_interleave();
    logic [1:0] chs  [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [3:0] vals [5] = '{4'd5, 4'd15, 4'd5, 4'd15, 4'd5};
    logic [8:0] exps [5] = '{9'd5, 9'd100, 9'd5, 9'd100, 9'd5};
    cfg_a(2'd1, 5'd0, 4'd1);
    cfg_a(2'd2, 5'd10, 4'd6);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_ch = chs[i]; sample_value = vals[i];
      tick();
      if (i > 0) begin
        checks++;
        if (temp_valid !== 1'b1 || temp_ch !== chs[i-1] || temp_out !== exps[i-1]) begin
          errors++;
          $display("FAIL interleave_%0d: got v=%b ch=%0d out=%0d want 1/%0d/%0d",
                   i - 1, temp_valid, temp_ch, temp_out, chs[i-1], exps[i-1]);
        end
      end
    end
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_out !== 9'd5 || temp_ch !== 2'd1 || low_alarm !== 4'b0000) begin
      errors++; $display("FAIL lo_early: got out=%0d ch=%0d lo=%b want 5/1/0000", temp_out, temp_ch, low_alarm);
    end
    tick();
    checks++;
    if (low_alarm !== 4'b0010 || high_alarm !== 4'b0000) begin
      errors++; $display("FAIL lo_set: got lo=%b hi=%b want 0010/0000", low_alarm, high_alarm);
    end
  endtask

  task automatic test_reset_flush();
    cfg_a(2'd0, 5'd10, 4'd15);
    sample_valid = 1'b1; sample_ch = 2'd0; sample_value = 4'd15;
    tick();
    tick();
    sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_rst: got %b want 0", sample_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (sample_ready !== 1'b0 || temp_valid !== 1'b0 || low_alarm !== 4'd0 || high_alarm !== 4'd0) begin
      errors++;
      $display("FAIL flush_after_rst: got rdy=%b v=%b lo=%b hi=%b want 0/0/0000/0000",
               sample_ready, temp_valid, low_alarm, high_alarm);
    end
    tick();
    checks++;
    if (sample_ready !== 1'b1 || temp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got rdy=%b v=%b want 1/0", sample_ready, temp_valid);
    end
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd0) begin
      errors++; $display("FAIL cfg_cleared: got v=%b out=%0d want 1/0", temp_valid, temp_out);
    end
    cfg_a(2'd0, 5'd10, 4'd15);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd235) begin
      errors++; $display("FAIL post_rst_temp: got v=%b out=%0d want 1/235", temp_valid, temp_out);
    end
    tick();
    tick();
    checks++;
    if (high_alarm !== 4'b0000 || low_alarm !== 4'b0000) begin
      errors++; $display("FAIL post_rst_alarm: got hi=%b lo=%b want 0000/0000", high_alarm, low_alarm);
    end
  endtask

  task automatic test_saturation();
    cfg_a(2'd3, 5'd31, 4'd15);
    sample_valid = 1'b1; sample_ch = 2'd3; sample_value = 4'd15;
    tick();
    sample_valid = 1'b0;
    tick();
    checks++;
    if (temp_valid !== 1'b1 || temp_out !== 9'd256 || temp_ch !== 2'd3) begin
      errors++; $display("FAIL sat_tw9: got v=%b out=%0d ch=%0d want 1/256/3", temp_valid, temp_out, temp_ch);
    end
    cfg_b(2'd1, 5'd31, 4'd14);
    sample_valid_b = 1'b1; sample_ch_b = 2'd1; sample_value_b = 4'd15;
    tick();
    sample_valid_b = 1'b0;
    tick();
    checks++;
    if (temp_valid_b !== 1'b1 || temp_out_b !== 8'd241) begin
      errors++; $display("FAIL nosat_tw8: got v=%b out=%0d want 1/241", temp_valid_b, temp_out_b);
    end
    cfg_b(2'd2, 5'd31, 4'd15);
    sample_valid_b = 1'b1; sample_ch_b = 2'd2; sample_value_b = 4'd15;
    tick();
    tick();
    checks++;
    if (temp_valid_b !== 1'b1 || temp_out_b !== 8'd255 || temp_ch_b !== 2'd2) begin
      errors++; $display("FAIL sat_tw8: got v=%b out=%0d ch=%0d want 1/255/2", temp_valid_b, temp_out_b, temp_ch_b);
    end
    tick();
    sample_valid_b = 1'b0;
    tick();
    tick();
    checks++;
    if (high_alarm_b !== 3'b100 || low_alarm_b !== 3'b000) begin
      errors++; $display("FAIL b_alarm: got hi=%b lo=%b want 100/000", high_alarm_b, low_alarm_b);
    end
  endtask

  task automatic test_bad_channel();
    sample_valid_b = 1'b1; sample_ch_b = 2'd3; sample_value_b = 4'd15;
    tick();
    sample_valid_b = 1'b0;
    checks++;
    if (ch_err_b !== 1'b0) begin
      errors++; $display("FAIL err_early: got %b want 0", ch_err_b);
    end
    tick();
    checks++;
    if (ch_err_b !== 1'b1 || temp_valid_b !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got err=%b v=%b want 1/0", ch_err_b, temp_valid_b);
    end
    tick();
    checks++;
    if (ch_err_b !== 1'b0 || temp_valid_b !== 1'b0 || high_alarm_b !== 3'b100 || low_alarm_b !== 3'b000) begin
      errors++;
      $display("FAIL err_after: got err=%b v=%b hi=%b lo=%b want 0/0/100/000",
               ch_err_b, temp_valid_b, high_alarm_b, low_alarm_b);
    end
    checks++;
    if (ch_err !== 1'b0) begin
      errors++; $display("FAIL err_default_dut: got %b want 0", ch_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_base = 5'd0; cfg_coef = 4'd0;
    sample_valid = 1'b0; sample_ch = 2'd0; sample_value = 4'd0; alarm_clr = 4'd0;
    cfg_we_b = 1'b0; cfg_ch_b = 2'd0; cfg_base_b = 5'd0; cfg_coef_b = 4'd0;
    sample_valid_b = 1'b0; sample_ch_b = 2'd0; sample_value_b = 4'd0; alarm_clr_b = 3'd0;
    test_reset();
    test_high_alarm();
    test_hysteresis();
    test_low_interleave();
    test_reset_flush();
    test_saturation();
    test_bad_channel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_temp_monitor.md
MULTI_CHANNEL_TEMP_MONITOR -- requirements
Module: multi_channel_temp_monitor

Interface
REQ-001 SHALL have parameter NCH, default 4: number of sensor channels (≥2).
REQ-002 SHALL have parameter BW, default 5: factory base temperature width.
REQ-003 SHALL have parameter CW, default 4: factory coefficient width.
REQ-004 SHALL have parameter SW, default 4: sensor value width.
REQ-005 SHALL have parameter TW, default 9: temperature width.
REQ-006 SHALL have parameters LOW_TH (20), HIGH_TH (200), HYST (10) and DEB (3): thresholds, hysteresis margin, and debounce sample count (≥1).
REQ-007 SHALL have ports clk (input, 1, clock) and rst (input, 1, synchronous active-high reset).
REQ-008 SHALL have config ports cfg_we (in, 1, write strobe), cfg_ch (in, $clog2(NCH), channel), cfg_base (in, BW, base) and cfg_coef (in, CW, coefficient).
REQ-009 SHALL have sample ports sample_valid (in, 1), sample_ready (out, 1), sample_ch (in, $clog2(NCH)) and sample_value (in, SW).
REQ-010 SHALL have result ports temp_valid (out, 1), temp_ch (out, $clog2(NCH)), temp_out (out, TW) and ch_err (out, 1, pulse).
REQ-011 SHALL have alarm ports low_alarm (out, NCH), high_alarm (out, NCH) and alarm_clr (in, NCH).

Function
REQ-012 A config write SHALL store cfg_base/cfg_coef for cfg_ch on the clock edge where cfg_we=1.
REQ-013 A sample SHALL be accepted on a clock edge where sample_valid=1 and sample_ready=1.
REQ-014 sample_ready SHALL be 0 in every cycle with rst=1 and in the cycle after rst deasserts, and 1 otherwise.
REQ-015 temp = base[ch] + coef[ch]*sample_value SHALL be computed unsigned and saturated to 2^TW-1 if it does not fit in TW bits.
REQ-016 A sample accepted at edge N SHALL produce temp_valid=1 with temp_ch and temp_out for exactly one cycle after edge N+1 (latency 1).
REQ-017 A sample with sample_ch ≥ NCH SHALL set ch_err=1 for one cycle after N+1, with temp_valid=0 and no state change.
REQ-018 A cfg write and a sample for the same channel at the same edge SHALL compute with the old config.
REQ-019 Per channel, the high counter SHALL increment on each sample with temp > HIGH_TH, saturating at DEB, and otherwise clear to 0.
REQ-020 The low counter SHALL behave the same way for temp < LOW_TH.
REQ-021 high_alarm[ch] SHALL set after edge N+2 of the sample that makes its counter reach DEB; low_alarm SHALL set in the same way.
REQ-022 Without sticky mode, high_alarm[ch] SHALL clear on a sample with temp ≤ HIGH_TH-HYST and hold for HIGH_TH-HYST < temp ≤ HIGH_TH.
REQ-023 Without sticky mode, low_alarm[ch] SHALL clear on a sample with temp ≥ LOW_TH+HYST and otherwise hold.
REQ-024 Samples on other channels SHALL NOT affect a channel's counters or alarms.
REQ-025 An alarm that sets and clears in the same cycle SHALL resolve with set winning.

Reset
REQ-026 rst SHALL clear all of the following to 0: config registers, counters, alarms, temp_valid, temp_out, temp_ch, ch_err and pipeline valids.
REQ-027 rst SHALL discard samples in flight, so no temp_valid or alarm update results from them.

Configuration
REQ-028 With TMON_STICKY_ALARM_EN defined, alarms SHALL ignore the REQ-022/023 clear conditions.
REQ-029 With TMON_STICKY_ALARM_EN defined, an alarm bit SHALL clear only on an edge where alarm_clr[ch]=1 and no set occurs.
REQ-030 Without TMON_STICKY_ALARM_EN, alarm_clr SHALL be ignored.

Verification (default parameters)
REQ-031 cfg ch0 base=10 coef=15, three ch0 samples value=15 on consecutive edges -> temp_out=235 each, high_alarm[0]=1 two cycles after the third sample, not before.
REQ-032 With high_alarm[0] set, sample temp 195 -> alarm holds; then temp 190 -> alarm clears (non-sticky); in sticky build both hold until alarm_clr[0]=1.
REQ-033 ch1 base=0 coef=1, ch1 value=5 (temp 5) interleaved with ch2 normal samples (temp 100), three ch1 samples -> low_alarm[1]=1, low_alarm[2]=0, high_alarm=0.
REQ-034 Two abnormal ch0 samples, rst for 1 cycle, config rewritten, one abnormal sample -> no alarm; sample_ready=0 during rst and the cycle after.
REQ-035 base=31 coef=15 value=15 -> temp_out=256; with TW=8 -> temp_out=255 (saturated).
REQ-036 With NCH=3, sample_ch=3 -> ch_err pulse for one cycle, temp_valid=0, all alarms unchanged.
